// File: rtl/manch_pkg.sv
// -----------------------------------------------------------------------------
// manch_pkg
// Definitions shared by the Manchester encoder and decoder:
//   manch_state_t  : frame sequencing states (IDLE, PRE, DATA, GAP)
//   ONE_FIRST_HALF : line level in the first half of a logical 1. The second
//                    half is always the inverse, so every bit has a mid-bit
//                    transition.
//   PRE_FIRST_BIT  : value of preamble bit 0. The preamble then alternates
//                    1,0,1,0,...
//   manch_level()  : line level for a bit value in a given half
// -----------------------------------------------------------------------------
package manch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } manch_state_t;

    // A logical 1 is low, then high. A logical 0 is high, then low.
    localparam logic ONE_FIRST_HALF = 1'b0;

    // Preamble bit k equals PRE_FIRST_BIT xor k[0].
    localparam logic PRE_FIRST_BIT = 1'b1;

    function automatic logic manch_level(input logic bit_val, input logic second_half);
        logic first_level;
        first_level = bit_val ? ONE_FIRST_HALF : ~ONE_FIRST_HALF;
        return first_level ^ second_half;
    endfunction

endpackage

// File: rtl/manch_bit_timer.sv
// -----------------------------------------------------------------------------
// manch_bit_timer
// Half-bit timebase for the Manchester encoder.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   enable : run the timer. While this input is low, the counter and the half
//            flag are held at 0, so every frame starts on a clean boundary.
//   strobe : high in the last cycle of each half-bit
//   half   : 0 during the first half of a bit, 1 during the second half
// -----------------------------------------------------------------------------
module manch_bit_timer #(
    parameter int HALF_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic strobe,
    output logic half
);

    // Keep at least one counter bit so that HALF_CYC = 1 stays legal.
    localparam int CNT_W = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CYC - 1);

    logic [CNT_W-1:0] cnt;

    assign strobe = enable && (cnt == CNT_LAST);

    // The half-period counter wraps to 0 at HALF_CYC-1.
    // The half flag toggles on each wrap.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt  <= '0;
            half <= 1'b0;
        end else if (strobe) begin
            cnt  <= '0;
            half <= ~half;
        end else begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/manch_encoder.sv
// -----------------------------------------------------------------------------
// manch_encoder
// Serialising Manchester encoder. It accepts one word through a valid/ready
// handshake, then sends a frame on the line:
//   - an alternating preamble,
//   - the word, MSB first,
//   - one bit time of low line (the gap).
// The line is held low between frames.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset; abandons any frame in progress
//   databin   : payload word, sampled only on the handshake
//   datavalid : upstream has a word
//   dataready : encoder is idle and can accept a word (state decode)
//   datamout  : Manchester line output, driven from a flop
//   busy      : a frame is in progress (preamble, data or gap)
// -----------------------------------------------------------------------------
module manch_encoder
    import manch_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int HALF_CYC = 4,
    parameter int PRE_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] databin,
    input  logic              datavalid,
    output logic              dataready,
    output logic              datamout,
    output logic              busy
);

    localparam int MAX_BITS = (PRE_BITS > DATA_W) ? PRE_BITS : DATA_W;
    localparam int BIT_W    = $clog2(MAX_BITS + 1);
    localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PRE_BITS - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    manch_state_t      state, state_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              half_n;
    logic              line_n;
    logic              strobe;
    logic              half;
    logic              bit_done;

    manch_bit_timer #(
        .HALF_CYC (HALF_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (state != IDLE),
        .strobe (strobe),
        .half   (half)
    );

    // A bit is complete at the end of its second half.
    assign bit_done = strobe && half;

    assign dataready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Next-state logic.
    // The line value is computed from the next state and next counters, so
    // the registered datamout stays aligned with the state it describes.
    // As a result, the first preamble half appears in the cycle right after
    // the handshake.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        half_n    = 1'b0;
        line_n    = 1'b0;

        case (state)
            IDLE: begin
                if (datavalid) begin
                    state_n   = PRE;
                    bit_cnt_n = '0;
                    shreg_n   = databin;
                end
            end
            PRE: begin
                if (bit_done) begin
                    if (bit_cnt == PRE_LAST) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            DATA: begin
                if (bit_done) begin
                    shreg_n = shreg << 1;
                    if (bit_cnt == DATA_LAST) begin
                        state_n   = GAP;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            GAP: begin
                if (bit_done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // The timer holds half at 0 while idle, so this also yields a
        // first half at the start of every frame.
        if (state_n != IDLE) begin
            half_n = half ^ strobe;
        end

        case (state_n)
            PRE:     line_n = manch_level(PRE_FIRST_BIT ^ bit_cnt_n[0], half_n);
            DATA:    line_n = manch_level(shreg_n[DATA_W-1], half_n);
            default: line_n = 1'b0;
        endcase
    end

    // State, counter, shift register and line flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            datamout <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            datamout <= line_n;
        end
    end

endmodule

// File: doc/manch_encoder.md
# manch_encoder

Serialising Manchester encoder that feeds the line input `datamin` of `manch_decoder`. It accepts one parallel word through a valid/ready handshake and transmits a fixed preamble followed by the word, MSB first, as a Manchester-coded serial stream on `datamout`. Each bit occupies two half-periods of `HALF_CYC` clocks. The line is held low between frames.

## Interface
- `DATA_W`, 8: payload width in bits.
- `HALF_CYC`, 4: clocks per Manchester half-bit; must be ≥ 1.
- `PRE_BITS`, 8: number of preamble bits; preamble pattern is 1,0,1,0,… starting with 1.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `databin`  in  DATA_W  payload word; sampled only on handshake.
- `datavalid`  in  1  upstream has a word.
- `dataready`  out  1  encoder can accept a word.
- `datamout`  out  1  Manchester line output, registered.
- `busy`  out  1  frame in progress, covering preamble, data and gap.

## Operation
- Coding: logical 0 is high for the first half, then low. Logical 1 is low for the first half, then high. There is therefore a mid-bit transition on every bit.
- State machine states: IDLE, PRE, DATA, GAP.
- IDLE
  - `dataready`=1, `busy`=0, `datamout`=0.
  - On `datavalid && dataready`, latch `databin` into the shift register, clear the bit and half counters, and go to PRE.
- PRE
  - Transmit `PRE_BITS` bits; bit k is 1 when k is even.
  - After the second half of the last preamble bit, go to DATA.
- DATA
  - Transmit the shift register MSB first, shifting left once per completed bit.
  - After bit `DATA_W-1` completes, go to GAP.
- GAP
  - `datamout`=0 for one full bit time (2·`HALF_CYC` clocks), then go to IDLE.
- Counters
  - Half-period counter: 0..`HALF_CYC-1`.
  - Half flag: 0 means first half, 1 means second half.
  - Bit counter: sized `$clog2(max(PRE_BITS,DATA_W)+1)`.
  - Each counter wraps to 0 at its terminal value. No other wrap behaviour exists.
- `datavalid` outside IDLE is ignored (`dataready`=0). `databin` changes after the handshake have no effect.
- `rst` at any cycle, including mid-frame, forces IDLE on the next edge and abandons the frame. No partial bit is completed.

## Timing
- Reset values: `dataready`=1, `busy`=0, `datamout`=0; state IDLE; all counters 0; shift register 0.
- Handshake cycle T (`datavalid`=1 in IDLE):
  - At T+1, `busy`=1 and `dataready`=0.
  - From T+1, `datamout` carries the first half of preamble bit 0 (low).
- Segment lengths:
  - Each half-bit lasts exactly `HALF_CYC` cycles.
  - Preamble: `PRE_BITS`·2·`HALF_CYC` cycles.
  - Data: `DATA_W`·2·`HALF_CYC` cycles.
  - Gap: 2·`HALF_CYC` cycles.
- Total frame length, from T+1 until `dataready` returns: (`PRE_BITS`+`DATA_W`+1)·2·`HALF_CYC` cycles. With defaults this is 136.
- Back-to-back: a new handshake is possible in the first IDLE cycle. The minimum inter-frame low time is the gap.
- `datamout` is driven directly from a flop. There are no combinational paths from inputs to any output except none: `dataready` is a state decode.

## Structure
- Shared package `manch_pkg` holds:
  - the state enum (IDLE, PRE, DATA, GAP);
  - the coding-polarity constant, also used by `manch_decoder`;
  - the default preamble pattern constant.
- Sub-module `manch_bit_timer`:
  - generates the half-period strobe and half flag from `clk`, `rst` and an enable;
  - the encoder FSM consumes its strobe.
- Expected size: about 150–220 lines in total.

## Test plan
- Reset idle: assert `rst` for 3 cycles, then release.
  - Required: `datamout`=0, `dataready`=1, `busy`=0.
  - These values must hold for 50 cycles with `datavalid`=0.
- Single frame, defaults: `databin`=8'hA5 with `datavalid` for 1 cycle.
  - First 64 cycles: the preamble waveform (low 4, high 4, high 4, low 4, …).
  - Next 64 cycles: bits 1,0,1,0,0,1,0,1 coded as specified.
  - Then 8 cycles low, then `dataready`=1 at exactly cycle 137 after the handshake.
- Back-to-back: hold `datavalid`=1 with 8'h00 then 8'hFF.
  - Second handshake occurs in the first IDLE cycle after frame 1.
  - 8'hFF data section shows low/high halves for every bit.
  - Loopback into `manch_decoder` recovers 0x00 then 0xFF.
- Ignored input: toggle `datavalid` and `databin` randomly during a frame carrying 8'h3C.
  - Transmitted payload remains 8'h3C.
  - Only one handshake is counted.
- Reset mid-frame: assert `rst` during DATA bit 3.
  - Next cycle: `datamout`=0, `dataready`=1.
  - A following frame with 8'h81 transmits correctly from its first preamble bit.
- Parameter corner: `HALF_CYC`=1, `PRE_BITS`=2, `DATA_W`=4, `databin`=4'hB.
  - Frame is 14 cycles.
  - Waveform: 0,1,1,0 (preamble), 0,1,1,0,0,1,0,1 (data), 0,0 (gap).
